wb_stage_mw: RTL

Parametrised multi-lane writeback stage for the LoongArch pipeline CPU, successor to the single-lane WB stage. Accepts up to LANES retiring instructions per cycle from MEM, commits register-file writes to ID over a per-lane write bus, and serialises retirements into the single-port debug trace interface through a small trace FIFO. When the FIFO lacks room, the stage back-pressures MEM.

---
 rtl/wb_stage_mw_pkg.sv | 22 ++
 rtl/wb_trace_fifo.sv | 76 +++++++
 rtl/wb_stage_mw.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_stage_mw_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_mw_pkg
// Shared widths for the multi-lane writeback stage.
//   - One MEM->WB lane is {gr_we, dest, result, pc}. A trace FIFO entry uses
//     the same layout {we, wnum, wdata, pc}, so a lane slice is pushed as is.
//   - One WB->ID lane is {rf_we, rf_waddr, rf_wdata}.
// No ports (package only).
// -----------------------------------------------------------------------------
package wb_stage_mw_pkg;

   localparam int PC_W     = 32;
   localparam int DBG_WE_W = 4;

   function automatic int mem_to_wb_lane_width(input int xlen, input int rw);
      return 1 + rw + xlen + PC_W;
   endfunction

   function automatic int wb_to_id_lane_width(input int xlen, input int rw);
      return 1 + rw + xlen;
   endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_trace_fifo
// Trace FIFO with up to LANES pushes and one pop per cycle. The FIFO pops
// its head every cycle that it holds an entry. The head is shown
// combinationally and reads as zero when the FIFO is empty.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   push_v       per-lane push strobes; the set bits form a prefix (lane 0 first)
//   push_data    per-lane entries, lane 0 in the LSBs
//   head_data    current head entry (zero when empty)
//   count        number of stored entries, 0..DEPTH
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module wb_trace_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 70,
   parameter  int LANES = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [LANES-1:0]       push_v,
   input  logic [LANES*WIDTH-1:0] push_data,
   output logic [WIDTH-1:0]       head_data,
   output logic [CW-1:0]          count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    push_n;
   logic             pop;

   always_comb begin
      pop    = (count_q != '0);
      push_n = '0;
      for (int i = 0; i < LANES; i++) begin
         push_n = push_n + CW'(push_v[i]);
      end
      // Valid lanes are contiguous from lane 0, so lane i lands at wr_ptr+i.
      // Pointers wrap naturally at the power-of-two depth.
      mem_d = mem_q;
      for (int i = 0; i < LANES; i++) begin
         if (push_v[i]) begin
            mem_d[wr_ptr_q + PW'(i)] = push_data[i*WIDTH +: WIDTH];
         end
      end
      wr_ptr_d = wr_ptr_q + PW'(push_n);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + push_n - CW'(pop);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is data only; count_q decides what is live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = pop ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;

endmodule

// File: rtl/wb_stage_mw.sv
// -----------------------------------------------------------------------------
// wb_stage_mw
// Multi-lane writeback stage. It holds one retiring group of up to LANES
// instructions from MEM and commits the register-file writes to ID. The
// lanes are serialised into the single-port debug trace through
// wb_trace_fifo. When the FIFO cannot take the held group, the stage stalls
// and back-pressures MEM.
// Build option: WB_DEBUG_TRACE_EN. When it is defined, the trace FIFO and
// back-pressure are present. When it is undefined, the stage never stalls
// and the debug outputs are tied to zero.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   mem_to_wb_bus      per lane {gr_we, dest, result, pc}, lane 0 in the LSBs
//   mem_to_wb_valid    per-lane valid (lane 1 valid implies lane 0 valid)
//   wb_allow_in        WB accepts a group this cycle
//   wb_to_id_bus       per lane {rf_we, rf_waddr, rf_wdata}
//   debug_wb_*         trace head: pc, replicated we, wnum, wdata
// -----------------------------------------------------------------------------
module wb_stage_mw
   import wb_stage_mw_pkg::*;
#(
   parameter  int XLEN      = 32,
   parameter  int NREG      = 32,
   parameter  int LANES     = 2,
   parameter  int DBG_DEPTH = 4,
   localparam int RW        = $clog2(NREG),
   localparam int ML        = mem_to_wb_lane_width(XLEN, RW),
   localparam int IL        = wb_to_id_lane_width(XLEN, RW)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [LANES*ML-1:0]   mem_to_wb_bus,
   input  logic [LANES-1:0]      mem_to_wb_valid,
   output logic                  wb_allow_in,
   output logic [LANES*IL-1:0]   wb_to_id_bus,
   output logic [PC_W-1:0]       debug_wb_pc,
   output logic [DBG_WE_W-1:0]   debug_wb_rf_we,
   output logic [RW-1:0]         debug_wb_rf_wnum,
   output logic [XLEN-1:0]       debug_wb_rf_wdata
);

   logic                  wb_valid_q, wb_valid_d;
   logic [LANES-1:0]      lane_v_q, lane_v_d;
   logic [LANES*ML-1:0]   payload_q, payload_d;
   logic                  ready_go;
   logic                  commit;
   logic [LANES-1:0]      wr_raw;
   logic [LANES-1:0]      rf_we;
   logic                  l_we   [LANES];
   logic [RW-1:0]         l_dest [LANES];
   logic [XLEN-1:0]       l_res  [LANES];

   // ---- MEM -> WB capture ----
   assign wb_allow_in = !wb_valid_q || ready_go;
   assign commit      = wb_valid_q && ready_go;

   always_comb begin
      wb_valid_d = wb_valid_q;
      lane_v_d   = lane_v_q;
      payload_d  = payload_q;
      if (wb_allow_in) begin
         wb_valid_d = |mem_to_wb_valid;
         lane_v_d   = mem_to_wb_valid;
         // Bubbles leave the payload untouched so ID keeps seeing stable data.
         if (|mem_to_wb_valid) begin
            payload_d = mem_to_wb_bus;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wb_valid_q <= 1'b0;
         lane_v_q   <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         lane_v_q   <= lane_v_d;
      end
   end

   always_ff @(posedge clk) begin
      payload_q <= payload_d;
   end

   // ---- WB -> ID commit ----
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign l_we[i]   = payload_q[i*ML + ML - 1];
      assign l_dest[i] = payload_q[i*ML + PC_W + XLEN +: RW];
      assign l_res[i]  = payload_q[i*ML + PC_W +: XLEN];
      assign wb_to_id_bus[i*IL +: IL] = {rf_we[i], l_dest[i], l_res[i]};
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         wr_raw[i] = commit && lane_v_q[i] && l_we[i] && (l_dest[i] != '0);
      end
      // A younger lane writing the same register wins; the older write is dropped.
      rf_we = wr_raw;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (wr_raw[j] && (l_dest[j] == l_dest[i])) begin
               rf_we[i] = 1'b0;
            end
         end
      end
   end

   // ---- WB -> debug trace ----
`ifdef WB_DEBUG_TRACE_EN
   localparam int CW = $clog2(DBG_DEPTH + 1);

   logic [CW-1:0]    trace_count;
   logic [CW-1:0]    need;
   logic [CW-1:0]    room;
   logic [LANES-1:0] push_v;
   logic [ML-1:0]    trace_head;

   // Room is judged before this cycle's pop, so the stall check errs on the safe side.
   always_comb begin
      need = '0;
      for (int i = 0; i < LANES; i++) begin
         need = need + CW'(lane_v_q[i]);
      end
      room     = CW'(DBG_DEPTH) - trace_count;
      ready_go = !wb_valid_q || (room >= need);
   end

   assign push_v = {LANES{commit}} & lane_v_q;

   wb_trace_fifo #(
      .DEPTH (DBG_DEPTH),
      .WIDTH (ML),
      .LANES (LANES)
   ) u_trace_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push_v    (push_v),
      .push_data (payload_q),
      .head_data (trace_head),
      .count     (trace_count)
   );

   assign debug_wb_pc       = trace_head[0 +: PC_W];
   assign debug_wb_rf_we    = {DBG_WE_W{trace_head[ML-1]}};
   assign debug_wb_rf_wnum  = trace_head[PC_W + XLEN +: RW];
   assign debug_wb_rf_wdata = trace_head[PC_W +: XLEN];
`else
   // Without the trace, the PC fields and the FIFO depth have no consumer.
   logic unused_trace;

   assign ready_go          = 1'b1;
   assign debug_wb_pc       = '0;
   assign debug_wb_rf_we    = '0;
   assign debug_wb_rf_wnum  = '0;
   assign debug_wb_rf_wdata = '0;
   assign unused_trace      = (DBG_DEPTH > 0) ^ (^payload_q);
`endif

endmodule
